// File: rtl/freq_div_pkg.sv
// Shared constants and state encoding for the programmable frequency divider.
package freq_div_pkg;

    localparam int unsigned FD_WIDTH         = 18;
    localparam int unsigned FD_DEFAULT_RATIO = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage : freq_div_pkg

// File: rtl/prog_freq_divider_if.sv
// Ratio-offer handshake: the offering side drives valid/ratio, the divider answers ready.
interface prog_freq_divider_if #(
    parameter int unsigned WIDTH = freq_div_pkg::FD_WIDTH
);

    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_ratio;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_ratio, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_ratio, output cfg_ready);

endinterface : prog_freq_divider_if

// File: rtl/freq_div_cfg.sv
// Ratio handshake: accepts offers, holds one pending ratio until the divider consumes it.
module freq_div_cfg
    import freq_div_pkg::*;
#(
    parameter int unsigned WIDTH = FD_WIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    prog_freq_divider_if.slave cfg,
    input  logic              direct,      // an accepted ratio goes straight into the active ratio
    input  logic              consume,     // the pending ratio is moved into the active ratio
    output logic              fire,        // offer accepted this cycle
    output logic              pend,
    output logic [WIDTH-1:0]  pend_ratio
);

    logic             pend_q, pend_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] p_q, p_d;

    // Next pending state: consume clears, a non-direct acceptance captures the ratio.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pend_d  = pend_q;
        p_d     = p_q;
        fire    = cfg.cfg_valid && ready_q;
        if (consume) begin
            pend_d = 1'b0;
        end else if (fire && !direct) begin
            pend_d = 1'b1;
            p_d    = cfg.cfg_ratio;
        end
        ready_d = !pend_d;
    end

    // Handshake registers; ready is kept as its own flop so the output is registered.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge and all state updates are non-blocking.
        if (!rstn) begin
            pend_q  <= 1'b0;
            p_q     <= '0;
            ready_q <= 1'b1;
        end else begin
            pend_q  <= pend_d;
            p_q     <= p_d;
            ready_q <= ready_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign pend          = pend_q;
    assign pend_ratio    = p_q;

endmodule : freq_div_cfg

// File: rtl/prog_freq_divider.sv
// Programmable divider: period counter, tick pulse and square wave with ratio handover at wrap.
module prog_freq_divider
    import freq_div_pkg::*;
#(
    parameter int unsigned WIDTH         = FD_WIDTH,
    parameter int unsigned DEFAULT_RATIO = FD_DEFAULT_RATIO
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_ratio,
    output logic             cfg_ready,
    output logic             tick,
    output logic             clk_out,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] RESET_RATIO = WIDTH'(DEFAULT_RATIO);

    prog_freq_divider_if #(.WIDTH(WIDTH)) cfg_bus ();

    assign cfg_bus.cfg_valid = cfg_valid;
    assign cfg_bus.cfg_ratio = cfg_ratio;
    assign cfg_ready         = cfg_bus.cfg_ready;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;

    logic             run;
    logic             wrap;
    logic             direct;
    logic             consume;
    logic             fire;
    logic             pend;
    logic [WIDTH-1:0] pend_ratio;

    freq_div_cfg #(.WIDTH(WIDTH)) u_cfg (
        .clk        (clk),
        .rstn       (rstn),
        .cfg        (cfg_bus),
        .direct     (direct),
        .consume    (consume),
        .fire       (fire),
        .pend       (pend),
        .pend_ratio (pend_ratio)
    );

    // Next state, active ratio, counter and the registered output values.
    always_comb begin
        run  = (state_q == ST_RUN);
        // A is at least 1 whenever RUN is entered, so A-1 never underflows here.
        wrap = run && (count_q == a_q - 1'b1);

        // Ratio boundaries: leaving IDLE with en, or a wrap that keeps running.
        // en=0 wins over a wrap, so a pending ratio waits for re-entry.
        direct  = !run || (en && wrap);
        consume = pend && en && (!run || wrap);

        a_d = a_q;
        if (consume) begin
            a_d = pend_ratio;
        end else if (fire && direct) begin
            a_d = cfg_ratio;
        end

        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en && (a_d != '0))          state_d = ST_RUN;
            ST_RUN:  if (!en || (wrap && a_d == '0)) state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase

        count_d = '0;
        if ((state_d == ST_RUN) && run && !wrap) begin
            count_d = count_q + 1'b1;
        end

        tick_d    = (state_d == ST_RUN) && (count_d == a_d - 1'b1);
        clk_out_d = (state_d == ST_RUN) && (count_d < (a_d >> 1));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            a_q       <= RESET_RATIO;
            count_q   <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign count   = count_q;
    assign tick    = tick_q;
    assign clk_out = clk_out_q;

endmodule : prog_freq_divider

// File: tb/tb_prog_freq_divider.sv
// Self-checking bench: directed table, corner sequences and random traffic against a period model.
module tb_prog_freq_divider;
    import freq_div_pkg::*;

    localparam int unsigned W = FD_WIDTH;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en;
    logic         tick;
    logic         clk_out;
    logic [W-1:0] count;

    prog_freq_divider_if #(.WIDTH(W)) bus ();

    prog_freq_divider #(.WIDTH(W), .DEFAULT_RATIO(FD_DEFAULT_RATIO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .cfg_valid (bus.cfg_valid),
        .cfg_ratio (bus.cfg_ratio),
        .cfg_ready (bus.cfg_ready),
        .tick      (tick),
        .clk_out   (clk_out),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: running flag, active ratio, position in period, pending queue.
    bit          m_run;
    int unsigned m_a;
    int unsigned m_pos;
    int unsigned m_pendq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic v, input int unsigned ratio);
        bit accepted;
        if (!r) begin
            m_run = 1'b0;
            m_a   = FD_DEFAULT_RATIO;
            m_pos = 0;
            m_pendq.delete();
            return;
        end
        accepted = v && (m_pendq.size() == 0);
        if (!m_run) begin
            if (accepted) m_a = ratio;
            if (e) begin
                if (m_pendq.size() != 0) m_a = m_pendq.pop_front();
                if (m_a > 0) begin
                    m_run = 1'b1;
                    m_pos = 0;
                end
            end
        end else if (!e) begin
            m_run = 1'b0;
            m_pos = 0;
            if (accepted) m_pendq.push_back(ratio);
        end else if (m_pos == m_a - 1) begin
            if (m_pendq.size() != 0) m_a = m_pendq.pop_front();
            else if (accepted)       m_a = ratio;
            m_pos = 0;
            if (m_a == 0) m_run = 1'b0;
        end else begin
            m_pos++;
            if (accepted) m_pendq.push_back(ratio);
        end
    endtask

    task automatic compare_model();
        check("count",     32'(count),         m_run ? m_pos : 0);
        check("tick",      32'(tick),          32'(m_run && (m_pos == m_a - 1)));
        check("clk_out",   32'(clk_out),       32'(m_run && (m_pos < m_a / 2)));
        check("cfg_ready", 32'(bus.cfg_ready), 32'(m_pendq.size() == 0));
    endtask

    // One clock: drive on the falling edge, step the model at the rising edge, sample just after.
    task automatic do_cycle(input logic r, input logic e, input logic v, input int unsigned ratio);
        @(negedge clk);
        rstn          = r;
        en            = e;
        bus.cfg_valid = v;
        bus.cfg_ratio = W'(ratio);
        @(posedge clk);
        model_step(r, e, v, ratio);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic        en;
        logic        valid;
        int unsigned ratio;
        int unsigned exp_count;
        logic        exp_tick;
        logic        exp_clk;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[20];

    initial begin
        bit          hit;
        int          n;
        int          highs;
        int          ticks;

        rstn          = 1'b0;
        en            = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ratio = '0;

        // Load 4, run two periods, then offer 6 at count=1 and 3 while 6 is pending.
        vecs[0]  = '{1'b0, 1'b1, 4, 0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 0, 1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 0, 2, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 0, 3, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 0, 1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 0, 2, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 0, 3, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 0, 1, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 6, 2, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 3, 3, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 0, 1, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 0, 2, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 0, 3, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 0, 4, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 0, 5, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1};

        // Reset state.
        do_cycle(1'b0, 1'b0, 1'b0, 0);
        check("reset count", 32'(count), 0);
        check("reset ready", 32'(bus.cfg_ready), 1);

        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, vecs[i].en, vecs[i].valid, vecs[i].ratio);
            check($sformatf("vec%0d count", i), 32'(count),         vecs[i].exp_count);
            check($sformatf("vec%0d tick", i),  32'(tick),          32'(vecs[i].exp_tick));
            check($sformatf("vec%0d clk", i),   32'(clk_out),       32'(vecs[i].exp_clk));
            check($sformatf("vec%0d ready", i), 32'(bus.cfg_ready), 32'(vecs[i].exp_ready));
        end

        // Odd ratio 5: two high cycles, three low, tick period 5.
        do_cycle(1'b0, 1'b0, 1'b0, 0);
        do_cycle(1'b1, 1'b0, 1'b1, 5);
        highs = 0;
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 0);
            if (k < 5) highs += int'(clk_out);
            ticks += int'(tick);
            if (k == 4 || k == 9) check("ratio5 tick position", 32'(tick), 1);
        end
        check("ratio5 high cycles", highs, 2);
        check("ratio5 ticks in 10", ticks, 2);

        // Ratio 2 offered exactly on a wrap cycle of ratio 4.
        do_cycle(1'b0, 1'b0, 1'b0, 0);
        do_cycle(1'b1, 1'b0, 1'b1, 4);
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (m_run && m_pos == 3) hit = 1'b1;
            else do_cycle(1'b1, 1'b1, 1'b0, 0);
        end
        check("reach wrap of 4", 32'(hit), 1);
        check("wrap cycle tick", 32'(tick), 1);
        do_cycle(1'b1, 1'b1, 1'b1, 2);
        check("offer at wrap count", 32'(count), 0);
        check("offer at wrap ready", 32'(bus.cfg_ready), 1);
        do_cycle(1'b1, 1'b1, 1'b0, 0);
        check("period 2 tick", 32'(tick), 1);
        do_cycle(1'b1, 1'b1, 1'b0, 0);
        check("period 2 restart", 32'(count), 0);

        // Drop en mid-period with ratio 8, then re-enter.
        do_cycle(1'b0, 1'b0, 1'b0, 0);
        do_cycle(1'b1, 1'b0, 1'b1, 8);
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (m_run && m_pos == 2) hit = 1'b1;
            else do_cycle(1'b1, 1'b1, 1'b0, 0);
        end
        check("reach count 2", 32'(hit), 1);
        do_cycle(1'b1, 1'b0, 1'b0, 0);
        check("en drop count", 32'(count), 0);
        check("en drop clk_out", 32'(clk_out), 0);
        do_cycle(1'b1, 1'b0, 1'b0, 0);
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 0);
            if (k == 1) check("re-entry count", 32'(count), 0);
            if (tick) n = k;
        end
        check("re-entry first tick cycle", n, 8);

        // Ratio 1 holds tick, then ratio 0 accepted at a wrap returns to IDLE.
        do_cycle(1'b0, 1'b0, 1'b0, 0);
        do_cycle(1'b1, 1'b0, 1'b1, 1);
        for (int k = 0; k < 3; k++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 0);
            check("ratio1 tick", 32'(tick), 1);
            check("ratio1 clk_out", 32'(clk_out), 0);
        end
        do_cycle(1'b1, 1'b1, 1'b1, 0);
        check("ratio0 tick", 32'(tick), 0);
        do_cycle(1'b1, 1'b1, 1'b0, 0);
        check("ratio0 stays idle", 32'(tick), 0);

        // Reset mid-period with a ratio pending.
        do_cycle(1'b1, 1'b0, 1'b1, 4);
        do_cycle(1'b1, 1'b1, 1'b0, 0);
        do_cycle(1'b1, 1'b1, 1'b0, 0);
        do_cycle(1'b1, 1'b1, 1'b1, 7);
        check("pending ready low", 32'(bus.cfg_ready), 0);
        do_cycle(1'b0, 1'b1, 1'b1, 9);
        check("reset mid count", 32'(count), 0);
        check("reset mid tick", 32'(tick), 0);
        check("reset mid clk_out", 32'(clk_out), 0);
        check("reset mid ready", 32'(bus.cfg_ready), 1);
        do_cycle(1'b1, 1'b1, 1'b0, 0);
        do_cycle(1'b1, 1'b1, 1'b0, 0);
        check("default ratio tick", 32'(tick), 1);

        // Largest ratio: counts up without wrapping, clk_out high in the first half.
        do_cycle(1'b0, 1'b0, 1'b0, 0);
        do_cycle(1'b1, 1'b0, 1'b1, (1 << W) - 1);
        for (int k = 0; k < 20; k++) do_cycle(1'b1, 1'b1, 1'b0, 0);
        check("max ratio count", 32'(count), 19);
        check("max ratio clk_out", 32'(clk_out), 1);

        // Random traffic against the model.
        do_cycle(1'b0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 3000; k++) begin
            do_cycle($urandom_range(0, 199) != 0,
                     $urandom_range(0, 15) != 0,
                     $urandom_range(0, 3) == 0,
                     ($urandom_range(0, 31) == 0) ? $urandom_range(10, 40) : $urandom_range(0, 9));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prog_freq_divider
